// File: rtl/ysyx_22040895_lsu_pkg.sv
// Shared widths, encodings and alignment helper for the ysyx_22040895 load/store unit.
package ysyx_22040895_lsu_pkg;

    localparam int ysyx_22040895_slLength    = 2;
    localparam int ysyx_22040895_munitLength = 2;

    typedef enum logic [ysyx_22040895_slLength-1:0] {
        SL_NONE  = 2'b00,
        SL_STORE = 2'b01,
        SL_LOAD  = 2'b10,
        SL_LOADU = 2'b11
    } sl_e;

    typedef enum logic [ysyx_22040895_munitLength-1:0] {
        MUNIT_B = 2'b00,
        MUNIT_H = 2'b01,
        MUNIT_W = 2'b10,
        MUNIT_D = 2'b11
    } munit_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10
    } lsu_state_e;

    // Byte-offset bits that must be zero for a naturally aligned access of this width.
    function automatic logic [2:0] offset_mask(input munit_e munit);
        case (munit)
            MUNIT_B: offset_mask = 3'b000;
            MUNIT_H: offset_mask = 3'b001;
            MUNIT_W: offset_mask = 3'b011;
            default: offset_mask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040895_lsu_align.sv
// Byte-lane steering for the LSU: store strobes and data shift, load shift and extension.
module ysyx_22040895_lsu_align
    import ysyx_22040895_lsu_pkg::*;
(
    input  logic [1:0]  wr_munit,
    input  logic [2:0]  wr_off,
    input  logic [63:0] wr_data,
    output logic [7:0]  wr_strb,
    output logic [63:0] wr_data_sh,
    input  logic [1:0]  rd_munit,
    input  logic [2:0]  rd_off,
    input  logic        rd_signed,
    input  logic [63:0] rd_data,
    output logic [63:0] rd_result
);

    logic [7:0]  strb_base;
    logic [63:0] rd_sh;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        strb_base = 8'h01;
        case (munit_e'(wr_munit))
            MUNIT_B: strb_base = 8'h01;
            MUNIT_H: strb_base = 8'h03;
            MUNIT_W: strb_base = 8'h0f;
            MUNIT_D: strb_base = 8'hff;
            default: strb_base = 8'h01;
        endcase
    end

    assign wr_strb    = strb_base << wr_off;
    assign wr_data_sh = wr_data << {wr_off, 3'b000};
    assign rd_sh      = rd_data >> {rd_off, 3'b000};

    always_comb begin
        rd_result = rd_sh;
        case (munit_e'(rd_munit))
            MUNIT_B: rd_result = {{56{rd_signed & rd_sh[7]}},  rd_sh[7:0]};
            MUNIT_H: rd_result = {{48{rd_signed & rd_sh[15]}}, rd_sh[15:0]};
            MUNIT_W: rd_result = {{32{rd_signed & rd_sh[31]}}, rd_sh[31:0]};
            MUNIT_D: rd_result = rd_sh;
            default: rd_result = rd_sh;
        endcase
    end

endmodule

// File: rtl/ysyx_22040895_lsu.sv
// Load/store unit: request/response handshake to data memory with pipeline stall.
// Define YSYX_22040895_MISALIGN_CHECK_EN to flag misaligned accesses instead of force-aligning them.
module ysyx_22040895_lsu
    import ysyx_22040895_lsu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               valid_i_lsu,
    input  logic [ysyx_22040895_slLength-1:0]  sl_i_lsu,
    input  logic [ysyx_22040895_munitLength-1:0] munit_i_lsu,
    input  logic [ADDR_W-1:0]                  addr_i_lsu,
    input  logic [DATA_W-1:0]                  wdata_i_lsu,
    output logic                               stall_o_lsu,
    output logic                               done_o_lsu,
    output logic [DATA_W-1:0]                  rdata_o_lsu,
    output logic                               misalign_o_lsu,
    output logic                               mem_req_o_lsu,
    output logic                               mem_we_o_lsu,
    output logic [ADDR_W-1:0]                  mem_addr_o_lsu,
    output logic [DATA_W-1:0]                  mem_wdata_o_lsu,
    output logic [7:0]                         mem_wstrb_o_lsu,
    input  logic                               mem_gnt_i_lsu,
    input  logic                               mem_rvalid_i_lsu,
    input  logic [DATA_W-1:0]                  mem_rdata_i_lsu
);

    lsu_state_e        state_q, state_d;
    sl_e               sl_q;
    munit_e            munit_q;
    logic [2:0]        off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wstrb_q;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rdata_q;

    logic              op_valid, aligned, accept;
    logic [2:0]        off_eff;
    logic [7:0]        wr_strb;
    logic [DATA_W-1:0] wr_data_sh, rd_result;

    // done_q blocks re-accepting the instruction that is still presented in its completion cycle.
    assign op_valid = (state_q == LSU_IDLE) & valid_i_lsu
                    & (sl_e'(sl_i_lsu) != SL_NONE) & ~done_q;

`ifdef YSYX_22040895_MISALIGN_CHECK_EN
    logic misalign_q;

    assign aligned = (addr_i_lsu[2:0] & offset_mask(munit_e'(munit_i_lsu))) == 3'b000;
    assign off_eff = addr_i_lsu[2:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) misalign_q <= 1'b0;
        else      misalign_q <= op_valid & ~aligned & ~misalign_q;
    end

    assign misalign_o_lsu = misalign_q;
`else
    assign aligned        = 1'b1;
    assign off_eff        = addr_i_lsu[2:0] & ~offset_mask(munit_e'(munit_i_lsu));
    assign misalign_o_lsu = 1'b0;
`endif

    assign accept = op_valid & aligned;

    ysyx_22040895_lsu_align u_align (
        .wr_munit   (munit_i_lsu),
        .wr_off     (off_eff),
        .wr_data    (wdata_i_lsu),
        .wr_strb    (wr_strb),
        .wr_data_sh (wr_data_sh),
        .rd_munit   (munit_q),
        .rd_off     (off_q),
        .rd_signed  (sl_q == SL_LOAD),
        .rd_data    (mem_rdata_i_lsu),
        .rd_result  (rd_result)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            LSU_IDLE: if (accept) state_d = LSU_REQ;
            LSU_REQ: begin
                if (mem_gnt_i_lsu) begin
                    state_d = (sl_q == SL_STORE) ? LSU_IDLE : LSU_WAIT;
                    done_d  = (sl_q == SL_STORE);
                end
            end
            LSU_WAIT: begin
                if (mem_rvalid_i_lsu) begin
                    state_d = LSU_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // NOTE: the capture registers are reset too, so every mem output reads 0 straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LSU_IDLE;
            done_q  <= 1'b0;
            rdata_q <= '0;
            sl_q    <= SL_NONE;
            munit_q <= MUNIT_B;
            off_q   <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= 8'h00;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (state_q == LSU_WAIT && mem_rvalid_i_lsu) rdata_q <= rd_result;
            if (accept) begin
                sl_q    <= sl_e'(sl_i_lsu);
                munit_q <= munit_e'(munit_i_lsu);
                off_q   <= off_eff;
                addr_q  <= {addr_i_lsu[ADDR_W-1:3], 3'b000};
                wdata_q <= wr_data_sh;
                wstrb_q <= wr_strb;
            end
        end
    end

    assign stall_o_lsu     = (state_q != LSU_IDLE) | accept;
    assign done_o_lsu      = done_q;
    assign rdata_o_lsu     = rdata_q;
    assign mem_req_o_lsu   = (state_q == LSU_REQ);
    assign mem_we_o_lsu    = (state_q == LSU_REQ) & (sl_q == SL_STORE);
    assign mem_addr_o_lsu  = addr_q;
    assign mem_wdata_o_lsu = wdata_q;
    assign mem_wstrb_o_lsu = wstrb_q;

endmodule

// File: tb/tb_ysyx_22040895_lsu.sv
// Self-checking bench for ysyx_22040895_lsu: transaction-level model plus per-cycle compare process.
module tb_ysyx_22040895_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0;
    logic [1:0]  sl_i = 2'b00;
    logic [1:0]  munit_i = 2'b00;
    logic [63:0] addr_i = '0;
    logic [63:0] wdata_i = '0;
    logic        stall, done, misalign, mem_req, mem_we;
    logic [63:0] rdata_o, mem_addr, mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;

    always #5 clk = ~clk;

    ysyx_22040895_lsu #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk              (clk),
        .rst              (rst),
        .valid_i_lsu      (valid_i),
        .sl_i_lsu         (sl_i),
        .munit_i_lsu      (munit_i),
        .addr_i_lsu       (addr_i),
        .wdata_i_lsu      (wdata_i),
        .stall_o_lsu      (stall),
        .done_o_lsu       (done),
        .rdata_o_lsu      (rdata_o),
        .misalign_o_lsu   (misalign),
        .mem_req_o_lsu    (mem_req),
        .mem_we_o_lsu     (mem_we),
        .mem_addr_o_lsu   (mem_addr),
        .mem_wdata_o_lsu  (mem_wdata),
        .mem_wstrb_o_lsu  (mem_wstrb),
        .mem_gnt_i_lsu    (gnt),
        .mem_rvalid_i_lsu (rvalid),
        .mem_rdata_i_lsu  (mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    // Expected per-cycle outputs, written by the sequencer, read by the compare process.
    logic        exp_stall = 1'b0, exp_req = 1'b0, exp_we = 1'b0, exp_done = 1'b0, exp_mis = 1'b0;
    logic [63:0] exp_addr = '0, exp_wdata = '0, exp_res_hold = '0;
    logic [7:0]  exp_strb = '0;

    logic [63:0] obs_addr = '0, obs_wdata = '0, obs_res = '0;
    logic [7:0]  obs_strb = '0;
    int          n_txn = 0;
    int          n_mis = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("stall", 64'(stall), 64'(exp_stall));
        check("mem_req", 64'(mem_req), 64'(exp_req));
        check("done", 64'(done), 64'(exp_done));
        check("misalign", 64'(misalign), 64'(exp_mis));
        check("rdata_o", rdata_o, exp_res_hold);
        if (exp_req) begin
            check("mem_we", 64'(mem_we), 64'(exp_we));
            check("mem_addr", mem_addr, exp_addr);
            check("mem_wstrb", 64'(mem_wstrb), 64'(exp_strb));
            if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
        end
        if (mem_req) begin
            obs_addr  <= mem_addr;
            obs_wdata <= mem_wdata;
            obs_strb  <= mem_wstrb;
        end
        if (mem_req && gnt) n_txn <= n_txn + 1;
        if (misalign)       n_mis <= n_mis + 1;
        if (done)           obs_res <= rdata_o;
    end

    // One instruction from presentation to completion, with gdly stall cycles before gnt
    // and rdly cycles between the first WAIT cycle and rvalid.
    task automatic run_op(input logic [1:0] sl, input logic [1:0] mu, input logic [63:0] addr,
                          input logic [63:0] wd, input logic [63:0] rd, input int gdly, input int rdly);
        int          bytes, off, eff, s;
        logic        mis;
        logic [63:0] mask, res;
        bytes = 1 << mu;
        off   = int'(addr[2:0]);
`ifdef YSYX_22040895_MISALIGN_CHECK_EN
        mis = (off % bytes) != 0;
        eff = off;
`else
        mis = 1'b0;
        eff = off - (off % bytes);
`endif
        mask = (bytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (bytes * 8)) - 64'd1);
        res  = (rd >> (eff * 8)) & mask;
        if (sl == 2'b10 && res[bytes*8-1]) res = res | ~mask;
        s = ((1 << bytes) - 1) << eff;

        @(posedge clk); #1;
        valid_i = 1'b1; sl_i = sl; munit_i = mu; addr_i = addr; wdata_i = wd;
        gnt = 1'b0; rvalid = 1'b0;
        exp_done = 1'b0; exp_mis = 1'b0; exp_req = 1'b0;
        if (sl == 2'b00 || mis) begin
            exp_stall = 1'b0;
            @(posedge clk); #1;
            valid_i = 1'b0; exp_mis = mis;
            @(posedge clk); #1;
            exp_mis = 1'b0;
            return;
        end
        exp_stall = 1'b1;
        exp_addr  = addr & ~64'h7;
        exp_strb  = 8'(s);
        exp_wdata = wd << (eff * 8);
        exp_we    = (sl == 2'b01);

        for (int i = 0; i <= gdly; i++) begin
            @(posedge clk); #1;
            exp_req   = 1'b1;
            gnt       = (i == gdly);
            rvalid    = 1'($urandom_range(0, 1));
            mem_rdata = {$urandom, $urandom};
            addr_i    = {$urandom, $urandom};
            wdata_i   = {$urandom, $urandom};
            munit_i   = 2'($urandom_range(0, 3));
        end
        @(posedge clk); #1;
        gnt = 1'b0; rvalid = 1'b0; exp_req = 1'b0;
        if (sl != 2'b01) begin
            for (int i = 0; i <= rdly; i++) begin
                if (i > 0) begin
                    @(posedge clk); #1;
                end
                rvalid    = (i == rdly);
                mem_rdata = (i == rdly) ? rd : {$urandom, $urandom};
            end
            @(posedge clk); #1;
            rvalid = 1'b0; mem_rdata = {$urandom, $urandom};
            exp_res_hold = res;
        end
        // Completion cycle: the same instruction is still presented and must not re-issue.
        exp_done = 1'b1; exp_stall = 1'b0;
        addr_i = addr; wdata_i = wd; munit_i = mu;
        @(posedge clk); #1;
        valid_i = 1'b0; exp_done = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            valid_i   = 1'($urandom_range(0, 1));
            sl_i      = 2'b00;
            rvalid    = 1'($urandom_range(0, 1));
            mem_rdata = {$urandom, $urandom};
        end
        @(posedge clk); #1;
        valid_i = 1'b0; rvalid = 1'b0;
    endtask

    initial begin
        int txn0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_rdata", rdata_o, 64'h0);
        check("reset_mem_addr", mem_addr, 64'h0);
        check("reset_wstrb", 64'(mem_wstrb), 64'h0);

        // sb to byte 3 with immediate grant
        run_op(2'b01, 2'b00, 64'h0000_0000_8000_0003, 64'h0000_0000_0000_00AB, 64'h0, 0, 0);
        check("sb_wstrb", 64'(obs_strb), 64'h08);
        check("sb_wdata", obs_wdata, 64'h0000_0000_AB00_0000);
        check("sb_addr", obs_addr, 64'h0000_0000_8000_0000);

        // lb / lbu from byte 5
        run_op(2'b10, 2'b00, 64'h0000_0000_8000_1005, 64'h0, 64'h0000_8000_0000_0000, 0, 0);
        check("lb_result", obs_res, 64'hFFFF_FFFF_FFFF_FF80);
        run_op(2'b11, 2'b00, 64'h0000_0000_8000_1005, 64'h0, 64'h0000_8000_0000_0000, 0, 0);
        check("lbu_result", obs_res, 64'h0000_0000_0000_0080);

        // lw upper word, grant after 3 stall cycles, rvalid 2 cycles after grant
        run_op(2'b10, 2'b10, 64'h0000_0000_8000_2004, 64'h0, 64'h8765_4321_0BAD_F00D, 3, 1);
        check("lw_result", obs_res, 64'hFFFF_FFFF_8765_4321);

        // back-to-back sd, valid held through each done cycle
        txn0 = n_txn;
        run_op(2'b01, 2'b11, 64'h0000_0000_8000_3000, 64'h1122_3344_5566_7788, 64'h0, 0, 0);
        run_op(2'b01, 2'b11, 64'h0000_0000_8000_3008, 64'h99AA_BBCC_DDEE_FF00, 64'h0, 1, 0);
        check("sd_txn_count", 64'(n_txn - txn0), 64'd2);
        check("sd_wstrb", 64'(obs_strb), 64'hFF);

        // lh at odd address
        txn0 = n_txn;
        run_op(2'b10, 2'b01, 64'h0000_0000_8000_4001, 64'h0, 64'h0000_0000_0000_8001, 0, 0);
`ifdef YSYX_22040895_MISALIGN_CHECK_EN
        check("lh_mis_no_txn", 64'(n_txn - txn0), 64'd0);
        check("lh_mis_pulses", 64'(n_mis), 64'd1);
`else
        check("lh_forced_addr", obs_addr, 64'h0000_0000_8000_4000);
        check("lh_forced_wstrb", 64'(obs_strb), 64'h03);
        check("lh_forced_result", obs_res, 64'hFFFF_FFFF_FFFF_8001);
`endif

        // reset while waiting for load data, then a late rvalid
        @(posedge clk); #1;
        valid_i = 1'b1; sl_i = 2'b10; munit_i = 2'b11; addr_i = 64'h0000_0000_8000_5000;
        exp_stall = 1'b1;
        exp_addr = 64'h0000_0000_8000_5000; exp_strb = 8'hFF; exp_we = 1'b0;
        @(posedge clk); #1;
        exp_req = 1'b1; gnt = 1'b1;
        @(posedge clk); #1;
        gnt = 1'b0; exp_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; valid_i = 1'b0; exp_stall = 1'b0; exp_res_hold = 64'h0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        @(posedge clk); #1;
        rvalid = 1'b0;
        @(negedge clk);
        check("rst_late_rdata", rdata_o, 64'h0);
        check("rst_late_done", 64'(done), 64'h0);

        // randomized traffic
        for (int k = 0; k < 200; k++) begin
            run_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), {$urandom, $urandom},
                   {$urandom, $urandom}, {$urandom, $urandom},
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            idle_cycles(int'($urandom_range(0, 2)));
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
